// File: rtl/output_buffer_if.sv
// Handshake bundle between the PE-array result stage, the output buffer and
// the output memory writer. Elements are two's complement values packed
// lane-major: lane k lives in [k].
interface output_buffer_if #(
   parameter int N_DIM_ARRAY       = 8,
   parameter int OUTPUT_DATA_WIDTH = 8,
   parameter int N_DIM_ARRAY_LOG   = $clog2(N_DIM_ARRAY)
);
   logic [N_DIM_ARRAY-1:0][OUTPUT_DATA_WIDTH-1:0] parallel_output_array;
   logic                                          load_valid;
   logic                                          load_ready;
   logic [N_DIM_ARRAY_LOG:0]                      shift_output_buffer;
   logic [N_DIM_ARRAY-1:0][OUTPUT_DATA_WIDTH-1:0] serial_output;
   logic [N_DIM_ARRAY_LOG:0]                      out_count;
   logic                                          out_valid;
   logic                                          out_ready;
   logic                                          out_last;
   logic [1:0]                                    occupancy;

   // Producer/consumer side: drives loads, beat size and downstream ready.
   modport master (
      output parallel_output_array, load_valid, shift_output_buffer, out_ready,
      input  load_ready, serial_output, out_count, out_valid, out_last, occupancy
   );

   // Buffer side.
   modport slave (
      input  parallel_output_array, load_valid, shift_output_buffer, out_ready,
      output load_ready, serial_output, out_count, out_valid, out_last, occupancy
   );
endinterface

// File: rtl/output_buffer.sv
// Ping-pong output buffer: captures N parallel PE results in one cycle and
// streams them out as variable-width beats of 1..N elements.
// Optional macro OUTPUT_BUFFER_RELU_EN clamps negative elements to 0 on load.
module output_buffer #(
   parameter int N_DIM_ARRAY       = 8,
   parameter int OUTPUT_DATA_WIDTH = 8,
   parameter int N_DIM_ARRAY_LOG   = $clog2(N_DIM_ARRAY)
) (
   input logic           clk,
   input logic           reset,
   input logic           clear,
   output_buffer_if.slave bus
);
   localparam int CW = N_DIM_ARRAY_LOG + 1;
   localparam logic [CW-1:0] N_CNT = CW'(N_DIM_ARRAY);

   typedef logic [N_DIM_ARRAY-1:0][OUTPUT_DATA_WIDTH-1:0] vec_t;

   vec_t          bank [2];
   logic [1:0]    full;
   logic          wr_sel;
   logic          rd_sel;
   logic [CW-1:0] rd_ptr;

   vec_t          load_data;
   vec_t          beat;
   logic [CW-1:0] beat_size;
   logic [CW-1:0] remaining;
   logic [CW-1:0] count;
   logic [CW-1:0] lane_idx;
   logic          valid;
   logic          last;
   logic          load_ready;

`ifdef OUTPUT_BUFFER_RELU_EN
   // Rectify each element on its way into the bank (sign bit set -> 0).
   always_comb begin
      load_data = '0;
      for (int k = 0; k < N_DIM_ARRAY; k++) begin
         if (!bus.parallel_output_array[k][OUTPUT_DATA_WIDTH-1]) begin
            load_data[k] = bus.parallel_output_array[k];
         end
      end
   end
`else
   // Elements are stored bit-exact.
   always_comb begin
      load_data = bus.parallel_output_array;
   end
`endif

   // Beat formation from registered state: size, lane count, last flag and
   // lane data, with unused lanes forced to 0.
   always_comb begin
      valid     = full[rd_sel];
      beat_size = (bus.shift_output_buffer == '0 || bus.shift_output_buffer > N_CNT)
                  ? N_CNT : bus.shift_output_buffer;
      remaining = N_CNT - rd_ptr;
      last      = valid && (beat_size >= remaining);
      count     = '0;
      if (valid) begin
         count = last ? remaining : beat_size;
      end
      beat     = '0;
      lane_idx = '0;
      for (int k = 0; k < N_DIM_ARRAY; k++) begin
         if (CW'(k) < count) begin
            lane_idx = rd_ptr + CW'(k);
            beat[k]  = bank[rd_sel][lane_idx[N_DIM_ARRAY_LOG-1:0]];
         end
      end
   end

   // Bank write pointer may only advance into an empty bank.
   assign load_ready = !full[wr_sel];

   assign bus.load_ready    = load_ready;
   assign bus.out_valid     = valid;
   assign bus.out_count     = count;
   assign bus.out_last      = last;
   assign bus.serial_output = beat;
   assign bus.occupancy     = 2'(full[0]) + 2'(full[1]);

   // Bank state update. A load always targets the empty write bank and a
   // drain always targets the full read bank, so the two never collide;
   // clear flushes everything and wins over both.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         bank[0] <= '0;
         bank[1] <= '0;
         full    <= '0;
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         rd_ptr  <= '0;
      end else begin
         if (bus.load_valid && load_ready) begin
            bank[wr_sel] <= load_data;
            full[wr_sel] <= 1'b1;
            wr_sel       <= ~wr_sel;
         end
         if (valid && bus.out_ready) begin
            if (last) begin
               full[rd_sel] <= 1'b0;
               rd_ptr       <= '0;
               rd_sel       <= ~rd_sel;
            end else begin
               rd_ptr <= rd_ptr + count;
            end
         end
      end
   end
endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: accepted loads push their elements
// into an expected element stream; a negedge monitor pops beats from it.
module tb_output_buffer;
   localparam int N  = 8;
   localparam int W  = 8;
   localparam int LG = $clog2(N);
   localparam int CW = LG + 1;

   typedef logic [N-1:0][W-1:0] vec_t;
   typedef struct {
      logic [W-1:0] data;
      bit           last;
   } elem_t;

   logic clk = 1'b0;
   logic reset;
   logic clear;

   output_buffer_if #(.N_DIM_ARRAY(N), .OUTPUT_DATA_WIDTH(W)) bus ();

   output_buffer #(.N_DIM_ARRAY(N), .OUTPUT_DATA_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   elem_t expQ[$];
   int    occ = 0;
   bit    synced = 0;
   bit    loadAccepted = 0;

   // Records one comparison and reports it if it does not hold.
   task automatic checkOutput(input string name, input logic [N*W-1:0] act,
                              input logic [N*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference for what a loaded element becomes inside the buffer.
   function automatic logic [W-1:0] storedValue(input logic [W-1:0] x);
`ifdef OUTPUT_BUFFER_RELU_EN
      return ($signed(x) < 0) ? '0 : x;
`else
      return x;
`endif
   endfunction

   // Monitor: checks every cycle's outputs against the expected stream, then
   // advances the model by what the coming edge will do.
   always @(negedge clk) begin : monitor
      int                occBefore;
      int                take;
      int                sz;
      bit                expLast;
      logic [N*W-1:0]    expBeat;
      occBefore = occ;
      take      = 0;
      expLast   = 0;
      expBeat   = '0;
      if (occ > 0) begin
         sz = int'(bus.shift_output_buffer);
         if (sz == 0 || sz > N) sz = N;
         while (take < sz && take < expQ.size()) begin
            expBeat[take*W +: W] = expQ[take].data;
            expLast = expQ[take].last;
            take++;
            if (expLast) break;
         end
      end
      if (synced) begin
         checkOutput("occupancy", (N*W)'(bus.occupancy), (N*W)'(occ));
         checkOutput("load_ready", (N*W)'(bus.load_ready), (N*W)'(occ < 2));
         checkOutput("out_valid", (N*W)'(bus.out_valid), (N*W)'(occ > 0));
         checkOutput("out_count", (N*W)'(bus.out_count), (N*W)'(take));
         checkOutput("out_last", (N*W)'(bus.out_last), (N*W)'(expLast));
         checkOutput("serial_output", bus.serial_output, expBeat);
      end
      loadAccepted = 0;
      if (reset || clear) begin
         expQ.delete();
         occ = 0;
         if (reset) synced = 1;
      end else if (synced) begin
         if (occBefore > 0 && bus.out_ready) begin
            for (int k = 0; k < take; k++) void'(expQ.pop_front());
            if (expLast) occ--;
         end
         if (bus.load_valid && occBefore < 2) begin
            for (int k = 0; k < N; k++) begin
               elem_t e;
               e.data = storedValue(bus.parallel_output_array[k]);
               e.last = (k == N - 1);
               expQ.push_back(e);
            end
            occ++;
            loadAccepted = 1;
         end
      end
   end

   // Drives one cycle of inputs, then advances to just after the next edge.
   task automatic applyStimulus(input bit lv, input vec_t data, input int sh,
                                input bit rdy, input bit clr, input bit rst);
      bus.load_valid            = lv;
      bus.parallel_output_array = data;
      bus.shift_output_buffer   = CW'(sh);
      bus.out_ready             = rdy;
      clear                     = clr;
      reset                     = rst;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t ramp(input int base);
      vec_t v;
      for (int k = 0; k < N; k++) v[k] = W'(base + k);
      return v;
   endfunction

   vec_t v;
   int   reluIn[N] = '{-5, 3, -128, 127, 0, -1, 8, 2};
   int   budget;

   initial begin
      // Reset and check idle outputs
      applyStimulus(0, '0, 3, 1, 0, 1);
      applyStimulus(0, '0, 3, 1, 0, 1);
      applyStimulus(0, '0, 3, 1, 0, 0);

      // Basic drain: three beats of 3,3,2
      applyStimulus(1, ramp(1), 3, 1, 0, 0);
      repeat (5) applyStimulus(0, '0, 3, 1, 0, 0);

      // Ping-pong back-to-back full-width beats
      applyStimulus(1, ramp(10), 0, 1, 0, 0);
      applyStimulus(1, ramp(20), 0, 1, 0, 0);
      repeat (4) applyStimulus(0, '0, 0, 1, 0, 0);

      // Backpressure: fill both banks, stall the third load, then release
      applyStimulus(1, ramp(30), 5, 0, 0, 0);
      applyStimulus(1, ramp(40), 5, 0, 0, 0);
      repeat (5) applyStimulus(1, ramp(50), 5, 0, 0, 0);
      repeat (3) applyStimulus(1, ramp(50), 5, 1, 0, 0);
      repeat (10) applyStimulus(0, '0, 5, 1, 0, 0);

      // Clear mid-drain, then reload from element 0
      applyStimulus(1, ramp(1), 2, 0, 0, 0);
      applyStimulus(0, '0, 2, 1, 0, 0);
      applyStimulus(1, ramp(60), 2, 1, 1, 0);
      applyStimulus(0, '0, 2, 1, 0, 0);
      applyStimulus(1, ramp(70), 2, 1, 0, 0);
      repeat (6) applyStimulus(0, '0, 2, 1, 0, 0);

      // Reset with both banks full
      applyStimulus(1, ramp(80), 4, 0, 0, 0);
      applyStimulus(1, ramp(90), 4, 0, 0, 0);
      applyStimulus(0, '0, 4, 0, 0, 1);
      applyStimulus(0, '0, 4, 1, 0, 0);

      // Signed vector (rectified only when the ReLU build is selected)
      for (int k = 0; k < N; k++) v[k] = W'(reluIn[k]);
      applyStimulus(1, v, 8, 1, 0, 0);
      repeat (3) applyStimulus(0, '0, 8, 1, 0, 0);

      // Random traffic with producer-hold and stall-stable beat size
      bus.load_valid = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!(bus.load_valid && !loadAccepted)) begin
            bus.load_valid = ($urandom_range(0, 99) < 55);
            for (int k = 0; k < N; k++) bus.parallel_output_array[k] = W'($urandom);
         end
         if (bus.out_ready) bus.shift_output_buffer = CW'($urandom_range(0, 15));
         bus.out_ready = ($urandom_range(0, 99) < 70);
         clear         = ($urandom_range(0, 199) == 0);
         @(posedge clk);
         #1;
      end

      // Drain whatever remains, bounded
      bus.load_valid = 0;
      bus.out_ready  = 1;
      clear          = 0;
      budget         = 0;
      while (occ > 0 && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      checkOutput("drain_timeout", (N*W)'(occ), '0);
      applyStimulus(0, '0, 1, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Drain-side counterpart of the activation input buffer.
- Captures the N parallel results of the MAC array in a single-cycle parallel load.
- Streams the results to the output memory writer as variable-width serial beats, with 1..N elements per beat.
- Ping-pong banking lets the array load the next result vector while the previous one drains.
- Sits between the PE array result stage and the output memory write path.

Parameters:
- N_DIM_ARRAY, 8, number of PE columns (elements per parallel load); power of two, at least 2.
- OUTPUT_DATA_WIDTH, 8, signed element width.
- N_DIM_ARRAY_LOG, $clog2(N_DIM_ARRAY), pointer width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of both banks and all pointers.
- parallel_output_array  input  OUTPUT_DATA_WIDTH x N_DIM_ARRAY  signed result vector from the PE array.
- load_valid  input  1  parallel_output_array is valid.
- load_ready  output  1  a bank is free to accept a load.
- shift_output_buffer  input  N_DIM_ARRAY_LOG+1  requested elements per beat; 0 is treated as N_DIM_ARRAY.
- serial_output  output  OUTPUT_DATA_WIDTH x N_DIM_ARRAY  beat data; lanes at index >= out_count are 0.
- out_count  output  N_DIM_ARRAY_LOG+1  number of valid lanes in the current beat.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  current beat drains the last elements of its bank.
- occupancy  output  2  number of full banks (0..2).

Behaviour:
- Storage: two banks of N_DIM_ARRAY elements each, with per-bank full flags. wr_sel and rd_sel are 1-bit bank selectors; rd_ptr is N_DIM_ARRAY_LOG+1 bits.
- Reset and clear (clear has the same effect as reset):
  - Bank contents are set to 0, full flags to 0, and wr_sel, rd_sel and rd_ptr to 0.
  - Resulting outputs: load_ready=1, out_valid=0, out_last=0, out_count=0, serial_output all 0, occupancy=0.
  - clear takes priority over a load or drain in the same cycle; that load or beat is dropped.
- Load:
  - load_ready = !full[wr_sel], computed from registered state only.
  - When load_valid and load_ready: bank[wr_sel] captures all N elements, full[wr_sel] is set, and wr_sel toggles.
  - If load_valid is high while load_ready is low, nothing is written and the producer must hold.
- Drain (combinational outputs from registered state):
  - out_valid = full[rd_sel].
  - s = (shift_output_buffer==0 or shift_output_buffer>N) ? N : shift_output_buffer.
  - rem = N - rd_ptr.
  - out_count = out_valid ? min(s, rem) : 0.
  - serial_output[k] = bank[rd_sel][rd_ptr+k] for k < out_count, otherwise 0.
  - out_last = out_valid and (s >= rem).
- Beat accept: when out_valid and out_ready, rd_ptr += out_count. If out_last, then full[rd_sel] is cleared, rd_ptr is set to 0 and rd_sel toggles.
- Stall rule: while out_valid and !out_ready, shift_output_buffer must be held stable. The beat contents must not change while stalled.
- Latency: an accepted load produces out_valid on the next cycle when the target bank is the read bank. Otherwise out_valid follows immediately after the preceding bank drains, with no bubble.
- Simultaneous load and last beat:
  - The bank freed by the last beat is not loadable in that cycle, because load_ready is registered-state based.
  - The other bank may be loaded in the same cycle.
  - occupancy changes by +1-1=0.
- Full case: with both banks full, load_ready=0 until a last beat is accepted.
- Arithmetic: no modification of data; it passes through bit-exact (see optional feature).

Optional Feature:
- Macro: OUTPUT_BUFFER_RELU_EN.
- Defined: on load, each element is written as max(element, 0); negative values are stored as 0. Control timing is unchanged.
- Undefined: elements are stored bit-exact. The ReLU logic is absent.

Test Plan:
- Basic drain (N=8, W=8):
  - Stimulus: after reset, load [1,2,3,4,5,6,7,8], shift=3, out_ready=1.
  - Response: next cycle out_valid=1. Beats are {1,2,3} count 3, {4,5,6} count 3, {7,8,0..} count 2 with out_last=1. Then out_valid=0 and occupancy=0.
- Ping-pong:
  - Stimulus: load A=[10..17], then B=[20..27] on consecutive cycles, shift=0 (treated as 8), out_ready=1.
  - Response: beats A then B back-to-back, each count 8 with out_last=1. load_ready is never 0.
- Backpressure and full:
  - Stimulus: out_ready=0, then load three vectors.
  - Response: the third load sees load_ready=0 and occupancy=2. The first beat is held stable for 5 stall cycles.
  - Raising out_ready then drains the vectors in order.
- Clear mid-drain:
  - Stimulus: load [1..8], shift=2, accept one beat, then assert clear together with out_ready.
  - Response: the next cycle has out_valid=0, occupancy=0 and load_ready=1. A new load restarts at element 0.
- Reset mid-operation:
  - Stimulus: both banks full, then assert reset for 1 cycle.
  - Response: all outputs are at their reset values the cycle after reset.
- Optional feature, with OUTPUT_BUFFER_RELU_EN defined:
  - Stimulus: load [-5,3,-128,127,0,-1,8,2], shift=8.
  - Response: the beat is [0,3,0,127,0,0,8,2].
  - Without the macro, the same stimulus returns the input unchanged.
